// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, checker FSM states and parity helpers.
// The TX parity generator imports the same package.
package uart_pkg;

    localparam logic [2:0] PAR_NONE  = 3'd0;
    localparam logic [2:0] PAR_EVEN  = 3'd1;
    localparam logic [2:0] PAR_ODD   = 3'd2;
    localparam logic [2:0] PAR_MARK  = 3'd3;
    localparam logic [2:0] PAR_SPACE = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_PAR  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Reserved encodings 5..7 collapse to NONE so they never demand a parity bit.
    function automatic logic [2:0] norm_mode(input logic [2:0] m);
        logic [2:0] r;
        case (m)
            PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE: r = m;
            default:                                r = PAR_NONE;
        endcase
        return r;
    endfunction

    // Parity bit that a correct frame carries, given the XOR of its data bits.
    function automatic logic exp_parity(input logic [2:0] mode, input logic acc);
        logic r;
        case (mode)
            PAR_EVEN:  r = acc;
            PAR_ODD:   r = ~acc;
            PAR_MARK:  r = 1'b1;
            PAR_SPACE: r = 1'b0;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_err_counter.sv
// Saturating error counter with sticky flag; clear takes priority over increment.
// Shared by the parity, framing and overrun error paths.
module uart_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             err_clr,
    input  logic             err_inc,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             sticky_r;
    logic [CNT_W-1:0] cnt_r;

    // Sticky flag and saturating count; a coincident clear discards the increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sticky_r <= 1'b0;
            cnt_r    <= '0;
        end else if (err_clr) begin
            sticky_r <= 1'b0;
            cnt_r    <= '0;
        end else if (err_inc) begin
            sticky_r <= 1'b1;
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

    assign sticky_err = sticky_r;
    assign err_cnt    = cnt_r;

endmodule

// File: rtl/uart_parity_checker.sv
// RX parity checker: accumulates a frame's data bits, compares the trailing
// parity bit against the mode latched at start, and reports per-frame and
// accumulated error status.
module uart_parity_checker
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             clr_err,
    output logic             busy,
    output logic             done,
    output logic             parity_err,
    output logic             sticky_err,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int              BIT_W    = $clog2(WIDTH + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);

    state_e           state_r;
    state_e           state_nx_s;
    logic [BIT_W-1:0] bit_cnt_r;
    logic             acc_r;
    logic [2:0]       mode_r;
    logic             busy_r;
    logic             done_r;
    logic             parity_err_r;
    logic             pe_nx_s;
    logic             bit_err_s;
    logic             err_inc_s;

    assign bit_err_s = (bit_in != exp_parity(mode_r, acc_r));

    // Next-state and next per-frame result; start from any state (re)opens a frame.
    always_comb begin
        state_nx_s = state_r;
        pe_nx_s    = parity_err_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (start) begin
                    state_nx_s = ST_DATA;
                end else if (bit_valid && (bit_cnt_r == LAST_BIT)) begin
                    if (mode_r == PAR_NONE) begin
                        state_nx_s = ST_DONE;
                        pe_nx_s    = 1'b0;
                    end else begin
                        state_nx_s = ST_PAR;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_PAR: begin
                if (start) begin
                    state_nx_s = ST_DATA;
                end else if (bit_valid) begin
                    state_nx_s = ST_DONE;
                    pe_nx_s    = bit_err_s;
                end else begin
                    state_nx_s = ST_PAR;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_nx_s = ST_DATA;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Frame datapath: mode latch, running XOR of data bits, accepted-bit count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_r    <= PAR_NONE;
            acc_r     <= 1'b0;
            bit_cnt_r <= '0;
        end else if (start) begin
            mode_r    <= norm_mode(mode);
            acc_r     <= 1'b0;
            bit_cnt_r <= '0;
        end else if ((state_r == ST_DATA) && bit_valid) begin
            acc_r     <= acc_r ^ bit_in;
            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
        end
    end

    // Registered status outputs derived from the next state, so done and the
    // fall of busy line up with the cycle the FSM sits in DONE.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            busy_r       <= (state_nx_s == ST_DATA) || (state_nx_s == ST_PAR);
            done_r       <= (state_nx_s == ST_DONE);
            parity_err_r <= pe_nx_s;
        end
    end

    // Error bookkeeping is committed while the FSM is in DONE.
    assign err_inc_s = (state_r == ST_DONE) && parity_err_r;

    uart_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_counter (
        .clk        (clk),
        .rstn       (rstn),
        .err_clr    (clr_err),
        .err_inc    (err_inc_s),
        .sticky_err (sticky_err),
        .err_cnt    (err_cnt)
    );

    assign busy       = busy_r;
    assign done       = done_r;
    assign parity_err = parity_err_r;

endmodule

// File: tb/tb_uart_parity_checker.sv
// Directed bench for uart_parity_checker. A second instance with CNT_W=2 shares
// the same stimulus to exercise counter saturation.
module tb_uart_parity_checker;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       clr_err = 1'b0;

    logic       busy, done, parity_err, sticky_err;
    logic [7:0] err_cnt;
    logic       busy2, done2, parity_err2, sticky_err2;
    logic [1:0] err_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    uart_parity_checker #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .clr_err(clr_err),
        .busy(busy), .done(done), .parity_err(parity_err),
        .sticky_err(sticky_err), .err_cnt(err_cnt)
    );

    uart_parity_checker #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode),
        .bit_valid(bit_valid), .bit_in(bit_in), .clr_err(clr_err),
        .busy(busy2), .done(done2), .parity_err(parity_err2),
        .sticky_err(sticky_err2), .err_cnt(err_cnt2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start with mode m, then scramble the mode input (must be ignored).
    task automatic do_start(input logic [2:0] m);
        start = 1'b1;
        mode  = m;
        tick();
        start = 1'b0;
        mode  = ~m;
    endtask

    // Drive 8 data bits LSB first with gap idle cycles between bits, then an
    // optional parity bit. early is set if done appears before the final bit.
    task automatic send_bits(input logic [7:0] d, input int gap, input bit par_en,
                             input logic p, output bit early);
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            bit_in    = d[i];
            tick();
            bit_valid = 1'b0;
            bit_in    = 1'b0;
            if (!(i == 7 && !par_en)) begin
                if (done) early = 1'b1;
                repeat (gap) begin
                    tick();
                    if (done) early = 1'b1;
                end
            end
        end
        if (par_en) begin
            bit_valid = 1'b1;
            bit_in    = p;
            tick();
            bit_valid = 1'b0;
            bit_in    = 1'b0;
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b want 0", parity_err); end
        n_checks++; if (sticky_err !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b want 0", sticky_err); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", err_cnt); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_even_ok();
        bit early;
        do_start(3'd1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL even_busy got %b want 1", busy); end
        send_bits(8'h5A, 0, 1'b1, 1'b0, early);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL even_early_done got %b want 0", early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL even_done got %b want 1", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL even_busy_fall got %b want 0", busy); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL even_perr got %b want 0", parity_err); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL even_done_pulse got %b want 0", done); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL even_cnt got %0d want 0", err_cnt); end
    endtask

    task automatic test_odd();
        bit early;
        do_start(3'd2);
        send_bits(8'h5A, 0, 1'b1, 1'b0, early);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL odd_bad_perr got %b want 1", parity_err); end
        tick();
        n_checks++; if (sticky_err !== 1'b1) begin n_fail++; $display("FAIL odd_bad_sticky got %b want 1", sticky_err); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL odd_bad_cnt got %0d want 1", err_cnt); end
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL odd_perr_hold got %b want 1", parity_err); end
        do_start(3'd2);
        send_bits(8'h5A, 0, 1'b1, 1'b1, early);
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL odd_ok_perr got %b want 0", parity_err); end
        tick();
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL odd_ok_cnt got %0d want 1", err_cnt); end
    endtask

    task automatic test_mark_space_none();
        bit early;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clr_cnt got %0d want 0", err_cnt); end
        n_checks++; if (sticky_err !== 1'b0) begin n_fail++; $display("FAIL clr_sticky got %b want 0", sticky_err); end
        do_start(3'd3);
        send_bits(8'h00, 0, 1'b1, 1'b0, early);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL mark_perr got %b want 1", parity_err); end
        tick();
        do_start(3'd4);
        send_bits(8'h00, 0, 1'b1, 1'b1, early);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL space_perr got %b want 1", parity_err); end
        tick();
        n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL markspace_cnt got %0d want 2", err_cnt); end
        do_start(3'd0);
        send_bits(8'hFF, 0, 1'b0, 1'b0, early);
        n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL none_early got %b want 0", early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL none_done got %b want 1", done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL none_perr got %b want 0", parity_err); end
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL none_no_par_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL none_no_par_done got %b want 0", done); end
        do_start(3'd7);
        send_bits(8'h01, 0, 1'b0, 1'b0, early);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mode7_done got %b want 1", done); end
        tick();
        n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL mode7_cnt got %0d want 2", err_cnt); end
    endtask

    task automatic test_gapped_abort();
        bit early;
        bit seen_done;
        logic [3:0] first_bits;
        first_bits = 4'b0111;
        seen_done  = 1'b0;
        do_start(3'd1);
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            bit_in    = first_bits[i];
            tick();
            bit_valid = 1'b0;
            if (done) seen_done = 1'b1;
            repeat (2) begin
                tick();
                if (done) seen_done = 1'b1;
            end
        end
        do_start(3'd2);
        if (done) seen_done = 1'b1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy got %b want 1", busy); end
        send_bits(8'h0F, 2, 1'b1, 1'b1, early);
        n_checks++; if ((seen_done | early) !== 1'b0) begin n_fail++; $display("FAIL abort_spurious_done got %b want 0", seen_done | early); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL abort_new_done got %b want 1", done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL abort_new_perr got %b want 0", parity_err); end
        tick();
        n_checks++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL abort_cnt got %0d want 2", err_cnt); end
    endtask

    task automatic test_saturate_clear();
        bit early;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        for (int f = 0; f < 5; f++) begin
            do_start(3'd3);
            send_bits(8'h00, 0, 1'b1, 1'b0, early);
            tick();
            if (f == 2) begin
                n_checks++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat3_cnt2 got %0d want 3", err_cnt2); end
            end
        end
        n_checks++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat5_cnt2 got %0d want 3", err_cnt2); end
        n_checks++; if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL sat5_cnt got %0d want 5", err_cnt); end
        do_start(3'd3);
        send_bits(8'h00, 0, 1'b1, 1'b0, early);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        n_checks++; if (err_cnt2 !== 2'd0) begin n_fail++; $display("FAIL clrwin_cnt2 got %0d want 0", err_cnt2); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL clrwin_cnt got %0d want 0", err_cnt); end
        n_checks++; if (sticky_err2 !== 1'b0) begin n_fail++; $display("FAIL clrwin_sticky got %b want 0", sticky_err2); end
        n_checks++; if (parity_err2 !== 1'b1) begin n_fail++; $display("FAIL clrwin_perr got %b want 1", parity_err2); end
    endtask

    task automatic test_back_to_back();
        bit early;
        do_start(3'd1);
        send_bits(8'h01, 0, 1'b1, 1'b0, early);
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL b2b_first_perr got %b want 1", parity_err); end
        do_start(3'd1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy got %b want 1", busy); end
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL b2b_cnt got %0d want 1", err_cnt); end
        n_checks++; if (sticky_err !== 1'b1) begin n_fail++; $display("FAIL b2b_sticky got %b want 1", sticky_err); end
        send_bits(8'h00, 0, 1'b1, 1'b0, early);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got %b want 1", done); end
        n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL b2b_second_perr got %b want 0", parity_err); end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        bit early;
        do_start(3'd1);
        for (int i = 0; i < 8; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_par_busy_pre got %b want 1", busy); end
        rstn = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b want 0", busy); end
        n_checks++; if (sticky_err !== 1'b0) begin n_fail++; $display("FAIL rst_async_sticky got %b want 0", sticky_err); end
        n_checks++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_async_cnt got %0d want 0", err_cnt); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done got %b want 0", done); end
        rstn = 1'b1;
        tick();
        do_start(3'd1);
        send_bits(8'h5A, 0, 1'b1, 1'b1, early);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL post_rst_done got %b want 1", done); end
        n_checks++; if (parity_err !== 1'b1) begin n_fail++; $display("FAIL post_rst_perr got %b want 1", parity_err); end
        tick();
        n_checks++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL post_rst_cnt got %0d want 1", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_even_ok();
        test_odd();
        test_mark_space_none();
        test_gapped_abort();
        test_saturate_clear();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_parity_checker.md
Name: uart_parity_checker

Overview:
- Parametrised receive-side parity checker for the UART RX path.
- Sits between the RX bit sampler and the RX frame assembler. Consumes one frame's data bits serially plus an optional parity bit.
- Computes expected parity per a run-time mode, flags mismatch per frame, and keeps sticky and counted error status for the CSR block.

Parameters:
- WIDTH, 8, data bits per frame (5..9 legal).
- CNT_W, 8, width of saturating parity-error counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse: new frame begins; samples mode.
- mode  in  3  0=NONE, 1=EVEN, 2=ODD, 3=MARK, 4=SPACE; 5..7 treated as NONE.
- bit_valid  in  1  bit_in is a valid sampled bit this cycle.
- bit_in  in  1  serial bit, LSB first; data bits, then parity bit.
- clr_err  in  1  clears sticky_err and err_cnt.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse: frame check complete.
- parity_err  out  1  result of last completed frame; valid when done is high, held until the next done.
- sticky_err  out  1  set on any frame error, held until clr_err.
- err_cnt  out  CNT_W  saturating count of frames with a parity error.

Behaviour:
- Reset (rstn low, async): state=IDLE; busy=0, done=0, parity_err=0, sticky_err=0, err_cnt=0; bit counter=0, accumulator=0, mode register=NONE.
- States: IDLE, DATA, PAR, DONE.
- IDLE:
  - start=1 → latch mode (5..7 latched as NONE), clear accumulator and counter, go to DATA.
  - bit_valid in IDLE is ignored, including in the start cycle.
- DATA:
  - On each bit_valid: acc ^= bit_in; cnt++.
  - On the WIDTH-th accepted bit: go to PAR, or to DONE if the latched mode is NONE.
  - bit_valid=0 → hold.
- PAR:
  - On bit_valid, compute expected parity: EVEN=acc; ODD=~acc; MARK=1; SPACE=0.
  - err_next = (bit_in != expected). Go to DONE.
- DONE (one cycle):
  - done=1; parity_err=err_next (0 for NONE).
  - If err_next: sticky_err=1 and err_cnt++ (saturates at 2^CNT_W-1).
  - Go to IDLE.
- Latency: done is high exactly one cycle after the final bit is accepted (parity bit, or last data bit for NONE). busy falls in the same cycle done rises.
- start while busy (DATA/PAR): abort the current frame with no done and no error update, restart in DATA with the newly sampled mode.
- start during DONE: the done pulse and error update still occur; the next state is DATA (new frame), not IDLE.
- clr_err and an error update in the same cycle: clear wins; sticky_err=0, err_cnt=0, and the frame error is not counted. parity_err still reports it.
- mode changes mid-frame have no effect; only the value sampled at start is used.
- The counter is sized $clog2(WIDTH+1). It never wraps within a frame; the transition fires on cnt==WIDTH-1 with bit_valid.
- Reset asserted mid-frame: immediate return to reset state; no done is produced.

Decomposition:
- Shared package uart_pkg:
  - parity-mode localparams (PAR_NONE..PAR_SPACE, 3 bits);
  - FSM state encoding;
  - function exp_parity(mode, acc).
  The TX parity generator reuses the same package.
- One natural sub-module: uart_err_counter. It holds the saturating CNT_W counter plus sticky flag, with clear-priority logic, and is reusable for framing and overrun errors.

Test Plan:
- EVEN, WIDTH=8, data 0x5A (four 1s), parity bit 0 → done one cycle after the parity bit; parity_err=0; err_cnt=0.
- ODD, data 0x5A, parity bit 0 → parity_err=1, sticky_err=1, err_cnt=1. Repeat with parity bit 1 → parity_err=0, err_cnt stays 1.
- MARK with parity bit 0, then SPACE with parity bit 1, data 0x00 → two errors, err_cnt=2. Then NONE with data 0xFF → done one cycle after the 8th bit; no parity bit consumed; parity_err=0.
- Gapped bit_valid (1 valid every 3 cycles); start mid-DATA after 4 bits → no done for the aborted frame; the new frame completes after 8 fresh bits + parity.
- CNT_W=2: force 5 error frames → err_cnt saturates at 3. Then clr_err coincident with the DONE of an error frame → err_cnt=0, sticky_err=0, parity_err=1.
- Assert rstn low during PAR → all outputs 0 asynchronously. After release, a full EVEN frame checks correctly.
